clock_monitor: RTL and testbench

CLOCK_MONITOR -- requirements
Module: clock_monitor

---
 rtl/clock_monitor.sv | 149 ++++++++++++++
 tb/tb_clock_monitor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_monitor.sv
// Frequency/presence monitor for an asynchronous clock sampled in the clk50 domain.
// Measures rising-edge spacing, locks after consecutive good periods, and flags faults.
module clock_monitor #(
  parameter int EXP_PERIOD = 10,
  parameter int TOL        = 1,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic       clk50,
  input  logic       i_reset,
  input  logic       i_clk_mon,
  input  logic       i_en,
  output logic       o_rise_tick,
  output logic [7:0] o_period,
  output logic       o_period_valid,
  output logic       o_locked,
  output logic       o_fault,
  output logic [7:0] o_fault_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACQUIRE = 3'd1,
    MEASURE = 3'd2,
    LOCKED  = 3'd3,
    FAULT   = 3'd4
  } state_t;

  localparam logic [9:0] EXP_W     = 10'(EXP_PERIOD);
  localparam logic [9:0] TOL_W     = 10'(TOL);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [8:0] LOCK_W    = 9'(LOCK_CNT);

  state_t     state, state_nxt;
  logic       s1, s2, s3;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] good_cnt, good_cnt_nxt;
  logic       first_seen, first_seen_nxt;
  logic       rise, timeout, measured, period_good;
  logic [9:0] cnt_w;

  // A rise event always wins over a timeout in the same cycle.
  assign rise        = s2 & ~s3;
  assign timeout     = (cnt == TIMEOUT_C) && !rise;
  assign measured    = rise && first_seen && (state != IDLE);
  assign cnt_w       = {2'b00, cnt};
  assign period_good = ((cnt_w + TOL_W) >= EXP_W) && (cnt_w <= (EXP_W + TOL_W));

  always_ff @(posedge clk50 or negedge i_reset) begin
    if (!i_reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= i_clk_mon;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    good_cnt_nxt   = good_cnt;
    first_seen_nxt = first_seen;
    if (!i_en) begin
      state_nxt      = IDLE;
      cnt_nxt        = 8'd0;
      good_cnt_nxt   = 8'd0;
      first_seen_nxt = 1'b0;
    end else begin
      if (state == IDLE)          cnt_nxt = 8'd0;
      else if (rise || timeout)   cnt_nxt = 8'd1;
      else if (cnt != 8'hFF)      cnt_nxt = cnt + 8'd1;
      if (rise && (state != IDLE)) first_seen_nxt = 1'b1;
      case (state)
        IDLE: begin
          state_nxt    = ACQUIRE;
          good_cnt_nxt = 8'd0;
        end
        ACQUIRE: begin
          if (rise)         state_nxt = MEASURE;
          else if (timeout) state_nxt = FAULT;
        end
        MEASURE: begin
          if (measured) begin
            if (period_good) begin
              good_cnt_nxt = good_cnt + 8'd1;
              if (({1'b0, good_cnt} + 9'd1) >= LOCK_W) state_nxt = LOCKED;
            end else begin
              good_cnt_nxt = 8'd0;
            end
          end else if (timeout) begin
            state_nxt    = FAULT;
            good_cnt_nxt = 8'd0;
          end
        end
        LOCKED: begin
          if ((measured && !period_good) || (!measured && timeout)) begin
            state_nxt    = FAULT;
            good_cnt_nxt = 8'd0;
          end
        end
        FAULT: begin
          if (measured && period_good) begin
            state_nxt    = MEASURE;
            good_cnt_nxt = 8'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk50 or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      good_cnt   <= 8'd0;
      first_seen <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      good_cnt   <= good_cnt_nxt;
      first_seen <= first_seen_nxt;
    end
  end

  // Status outputs are registered from the next state so they track state exactly.
  always_ff @(posedge clk50 or negedge i_reset) begin
    if (!i_reset) begin
      o_rise_tick    <= 1'b0;
      o_period       <= 8'd0;
      o_period_valid <= 1'b0;
      o_locked       <= 1'b0;
      o_fault        <= 1'b0;
      o_fault_cnt    <= 8'd0;
    end else begin
      o_rise_tick    <= rise;
      o_period_valid <= i_en && measured;
      if (i_en && measured) o_period <= cnt;
      o_locked       <= (state_nxt == LOCKED);
      o_fault        <= (state_nxt == FAULT);
      if ((state_nxt == FAULT) && (state != FAULT) && (o_fault_cnt != 8'hFF))
        o_fault_cnt <= o_fault_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: directed table, corner sequences and random segments,
// all checked cycle by cycle against a timestamp-based reference model.
module tb_clock_monitor;
  localparam int EXP  = 10;
  localparam int TOL  = 1;
  localparam int LOCK = 4;
  localparam int TMO  = 64;

  localparam int M_IDLE = 0, M_ACQ = 1, M_MEAS = 2, M_LOCK = 3, M_FLT = 4;

  logic       clk50 = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_clk_mon = 1'b0;
  logic       i_en = 1'b0;
  logic       o_rise_tick, o_period_valid, o_locked, o_fault;
  logic [7:0] o_period, o_fault_cnt;

  int vectors = 0;
  int miscompares = 0;

  clock_monitor #(.EXP_PERIOD(EXP), .TOL(TOL), .LOCK_CNT(LOCK), .TIMEOUT(TMO)) dut (
    .clk50(clk50), .i_reset(i_reset), .i_clk_mon(i_clk_mon), .i_en(i_en),
    .o_rise_tick(o_rise_tick), .o_period(o_period), .o_period_valid(o_period_valid),
    .o_locked(o_locked), .o_fault(o_fault), .o_fault_cnt(o_fault_cnt)
  );

  always #10 clk50 = ~clk50;

  // Reference model: periods are differences of cycle timestamps.
  int   edge_n = 0;
  int   ref_cyc, good_run, m_state;
  bit   first;
  logic mon_q[$];
  logic exp_tick, exp_pv, exp_locked, exp_fault;
  int   exp_period, exp_fcnt;

  task automatic model_reset();
    m_state = M_IDLE; first = 0; good_run = 0; ref_cyc = 0;
    mon_q = '{1'b0, 1'b0, 1'b0};
    exp_tick = 0; exp_pv = 0; exp_locked = 0; exp_fault = 0;
    exp_period = 0; exp_fcnt = 0;
  endtask

  task automatic model_step();
    bit rise, good;
    int cnt, cur;
    edge_n++;
    rise = mon_q[1] && !mon_q[2];
    cur  = m_state;
    cnt  = (cur == M_IDLE) ? 0 : (((edge_n - 1) - ref_cyc) > 255 ? 255 : (edge_n - 1) - ref_cyc);
    exp_tick = rise;
    exp_pv   = 0;
    if (!i_en) begin
      m_state = M_IDLE; first = 0; good_run = 0;
    end else if (cur == M_IDLE) begin
      m_state = M_ACQ; ref_cyc = edge_n;
    end else if (rise) begin
      ref_cyc = edge_n - 1;
      if (!first) begin
        first = 1;
        if (cur == M_ACQ) m_state = M_MEAS;
      end else begin
        good = (cnt >= EXP - TOL) && (cnt <= EXP + TOL);
        exp_pv = 1; exp_period = cnt;
        if (cur == M_MEAS) begin
          if (good) begin
            good_run++;
            if (good_run >= LOCK) m_state = M_LOCK;
          end else good_run = 0;
        end else if (cur == M_LOCK) begin
          if (!good) m_state = M_FLT;
        end else if (cur == M_FLT) begin
          if (good) begin m_state = M_MEAS; good_run = 1; end
        end
      end
    end else if (cnt == TMO) begin
      ref_cyc = edge_n - 1;
      m_state = M_FLT;
    end
    if (m_state == M_FLT && cur != M_FLT && exp_fcnt < 255) exp_fcnt++;
    exp_locked = (m_state == M_LOCK);
    exp_fault  = (m_state == M_FLT);
    mon_q.push_front(i_clk_mon);
    void'(mon_q.pop_back());
  endtask

  always @(posedge clk50 or negedge i_reset) begin
    if (!i_reset) model_reset();
    else model_step();
  end

  task automatic model_cmp();
    vectors++;
    if (o_rise_tick !== exp_tick || o_period_valid !== exp_pv || o_locked !== exp_locked ||
        o_fault !== exp_fault || o_period !== 8'(exp_period) || o_fault_cnt !== 8'(exp_fcnt)) begin
      miscompares++;
      $display("FAIL model_cycle t=%0t got tick=%0b pv=%0b per=%0d lk=%0b flt=%0b fc=%0d expected tick=%0b pv=%0b per=%0d lk=%0b flt=%0b fc=%0d",
               $time, o_rise_tick, o_period_valid, o_period, o_locked, o_fault, o_fault_cnt,
               exp_tick, exp_pv, exp_period, exp_locked, exp_fault, exp_fcnt);
    end
  endtask

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk50);
    model_cmp();
  endtask

  task automatic drive_clk(int hi, int lo, int n);
    for (int k = 0; k < n; k++) begin
      i_clk_mon = 1'b1;
      repeat (hi) tick();
      i_clk_mon = 1'b0;
      repeat (lo) tick();
    end
  endtask

  typedef struct {
    int   hi; int lo; int n; logic en;
    logic locked; logic fault; int period; int fcnt;
  } vec_t;
  vec_t tbl[$];

  initial begin
    int   waits;
    logic seen, pv_at;
    tbl.push_back('{5, 5, 6, 1'b1, 1'b1, 1'b0, 10, 0});
    tbl.push_back('{5, 5, 1, 1'b1, 1'b1, 1'b0, 10, 0});
    tbl.push_back('{6, 6, 1, 1'b1, 1'b1, 1'b0, 10, 0});
    tbl.push_back('{5, 5, 1, 1'b1, 1'b0, 1'b1, 12, 1});
    tbl.push_back('{5, 5, 1, 1'b1, 1'b0, 1'b0, 10, 1});
    tbl.push_back('{5, 5, 3, 1'b1, 1'b1, 1'b0, 10, 1});
    tbl.push_back('{5, 5, 1, 1'b0, 1'b0, 1'b0, 10, 1});
    tbl.push_back('{5, 4, 1, 1'b1, 1'b0, 1'b0, 10, 1});
    tbl.push_back('{6, 5, 1, 1'b1, 1'b0, 1'b0,  9, 1});
    tbl.push_back('{5, 4, 1, 1'b1, 1'b0, 1'b0, 11, 1});
    tbl.push_back('{6, 5, 1, 1'b1, 1'b0, 1'b0,  9, 1});
    tbl.push_back('{5, 4, 1, 1'b1, 1'b1, 1'b0, 11, 1});
    tbl.push_back('{5, 5, 1, 1'b0, 1'b0, 1'b0, 11, 1});
    tbl.push_back('{4, 4, 1, 1'b1, 1'b0, 1'b0, 11, 1});
    tbl.push_back('{5, 5, 2, 1'b1, 1'b0, 1'b0, 10, 1});
    tbl.push_back('{5, 5, 3, 1'b1, 1'b1, 1'b0, 10, 1});

    #1 i_reset = 1'b0;
    repeat (3) tick();
    chk("reset_locked", o_locked, 0);
    chk("reset_fcnt", o_fault_cnt, 0);
    #3 i_reset = 1'b1;
    tick();

    foreach (tbl[i]) begin
      i_en = tbl[i].en;
      drive_clk(tbl[i].hi, tbl[i].lo, tbl[i].n);
      chk($sformatf("row%0d_locked", i), o_locked, tbl[i].locked);
      chk($sformatf("row%0d_fault", i), o_fault, tbl[i].fault);
      chk($sformatf("row%0d_period", i), o_period, tbl[i].period);
      chk($sformatf("row%0d_fcnt", i), o_fault_cnt, tbl[i].fcnt);
    end

    // Stuck clock after lock.
    i_clk_mon = 1'b0;
    waits = 0;
    while (!o_fault && waits < 100) begin tick(); waits++; end
    chk("stuck_fault_latency", waits, 57);
    chk("stuck_fcnt", o_fault_cnt, 2);
    repeat (200) tick();
    chk("stuck_fault_held", o_fault, 1);
    chk("stuck_fcnt_held", o_fault_cnt, 2);

    // Relock, then a rise exactly when cnt reaches the timeout.
    drive_clk(5, 5, 6);
    chk("relock", o_locked, 1);
    chk("relock_fcnt", o_fault_cnt, 2);
    drive_clk(5, 59, 1);
    drive_clk(5, 5, 1);
    chk("simul_period", o_period, 64);
    chk("simul_fault", o_fault, 1);
    chk("simul_fcnt", o_fault_cnt, 3);

    // Enable dropped while locked.
    drive_clk(5, 5, 6);
    chk("en_pre_locked", o_locked, 1);
    i_en = 1'b0;
    tick();
    chk("en_drop_locked", o_locked, 0);
    chk("en_drop_fault", o_fault, 0);
    chk("en_drop_period", o_period, 10);
    chk("en_drop_fcnt", o_fault_cnt, 3);
    i_en = 1'b1;

    // Reset pulsed mid-period.
    drive_clk(5, 5, 6);
    chk("rst_pre_locked", o_locked, 1);
    i_clk_mon = 1'b1;
    repeat (3) tick();
    #3 i_reset = 1'b0;
    #1;
    chk("rst_now_outputs", {o_rise_tick, o_period_valid, o_locked, o_fault}, 0);
    chk("rst_now_period", o_period, 0);
    chk("rst_now_fcnt", o_fault_cnt, 0);
    tick();
    #3 i_reset = 1'b1;
    seen = 0; pv_at = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 2) i_clk_mon = 1'b0;
      if (o_rise_tick) begin seen = 1'b1; pv_at = o_period_valid; end
    end
    chk("rst_first_rise_seen", seen, 1);
    chk("rst_first_rise_no_pv", pv_at, 0);
    drive_clk(5, 5, 3);
    chk("rst_after_period", o_period, 10);

    // Random segments against the model.
    for (int s = 0; s < 150; s++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        i_en = 1'b0;
        repeat ($urandom_range(3, 20)) tick();
        i_en = 1'b1;
      end else if (kind == 1) begin
        i_clk_mon = 1'b0;
        repeat ($urandom_range(50, 140)) tick();
      end else if (kind == 2) begin
        #3 i_reset = 1'b0;
        tick();
        #3 i_reset = 1'b1;
        tick();
      end else begin
        drive_clk($urandom_range(3, 7), $urandom_range(3, 7), $urandom_range(1, 6));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
